// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core types and constants for the fetch stage
// Purpose: common widths, the NOP encoding, the fetch entry layout and the boot address.
package core_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] RV_NOP            = 32'h0000_0013;
  localparam logic [XLEN-1:0] BOOT_ADDR_DEFAULT = 32'h0000_0004;

  // One prefetch entry: the fetched word and the byte PC it came from.
  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small prefetch FIFO with flush
// Purpose: buffers fetched entries between the SRAM and decode.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   push_i, data_i   write an entry (caller guarantees room)
//   pop_i            consume the head (caller guarantees not empty)
//   flush_i          discard all entries; wins over push
//   full_o, empty_o  occupancy status
//   head_o           head entry; holds the last head value while empty
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0]   count_q;
  logic [W-1:0]  last_q;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  // Once drained, the output keeps showing the most recent head instead of a stale slot.
  assign head_o  = empty_o ? last_q : mem[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (!empty_o) last_q <= mem[rd_ptr_q];
      if (flush_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push_i) begin
          mem[wr_ptr_q] <= data_i;
          wr_ptr_q      <= wr_ptr_q + 1'b1;
        end
        if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
        case ({push_i, pop_i})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: PC, SRAM requests, prefetch FIFO to decode
// Purpose: holds the PC, reads the word-addressed instruction SRAM and offers words to decode.
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   fetch_en_i                         allow new requests
//   instr_req_o/we_o/addr_o/rdata_i    SRAM interface (combinational read data)
//   branch_i, branch_target_i          one-cycle redirect from execute
//   instr_valid_o, instr_ready_i       decode handshake
//   instr_o, instr_pc_o                head word and its byte PC
module instr_fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR  = BOOT_ADDR_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_en_i,
  output logic        instr_req_o,
  output logic        instr_we_o,
  output logic [31:0] instr_addr_o,
  input  logic [31:0] instr_rdata_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o
);

  logic [31:0]  pc_q;
  logic         fifo_full, fifo_empty;
  logic         pop, room;
  fetch_entry_t push_entry, head_entry;

  assign instr_valid_o = ~fifo_empty & ~rst_i;
  assign pop           = instr_valid_o & instr_ready_i;
  // A pop in the same cycle frees a slot, so a full FIFO keeps streaming.
  assign room          = ~fifo_full | pop;
  assign instr_req_o   = fetch_en_i & room & ~branch_i & ~rst_i;
  assign instr_we_o    = 1'b0;
  assign instr_addr_o  = {2'b00, pc_q[31:2]};

  assign push_entry = '{instr: instr_rdata_i, pc: pc_q};

  assign instr_o    = rst_i ? 32'h0 : head_entry.instr;
  assign instr_pc_o = rst_i ? 32'h0 : head_entry.pc;

  always_ff @(posedge clk_i) begin
    if (rst_i)            pc_q <= BOOT_ADDR;
    else if (branch_i)    pc_q <= {branch_target_i[31:2], 2'b00};
    else if (instr_req_o) pc_q <= pc_q + 32'd4;
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(fetch_entry_t))
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (instr_req_o),
    .data_i  (push_entry),
    .pop_i   (pop),
    .flush_i (branch_i),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head_entry)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  localparam logic [31:0] BOOT  = 32'h0000_0004;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_i, fetch_en_i, branch_i, instr_ready_i;
  logic [31:0] branch_target_i, instr_rdata_i;
  logic        instr_req_o, instr_we_o, instr_valid_o;
  logic [31:0] instr_addr_o, instr_o, instr_pc_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] sram_word(input logic [31:0] a);
    return 32'h1000_0000 + a;
  endfunction

  assign instr_rdata_i = instr_req_o ? sram_word(instr_addr_o) : 32'hDEAD_BEEF;

  instr_fetch_unit #(.BOOT_ADDR(BOOT), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .fetch_en_i      (fetch_en_i),
    .instr_req_o     (instr_req_o),
    .instr_we_o      (instr_we_o),
    .instr_addr_o    (instr_addr_o),
    .instr_rdata_i   (instr_rdata_i),
    .branch_i        (branch_i),
    .branch_target_i (branch_target_i),
    .instr_valid_o   (instr_valid_o),
    .instr_ready_i   (instr_ready_i),
    .instr_o         (instr_o),
    .instr_pc_o      (instr_pc_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: a queue of {instr, pc} plus the next fetch PC.
  logic [63:0] mq[$];
  logic [31:0] mpc = BOOT;

  always @(negedge clk) begin
    logic exp_valid, exp_req, exp_pop;
    exp_valid = (mq.size() > 0) && !rst_i;
    exp_pop   = exp_valid && instr_ready_i;
    exp_req   = fetch_en_i && ((mq.size() < DEPTH) || exp_pop) && !branch_i && !rst_i;
    chk("m_valid", {31'b0, instr_valid_o}, {31'b0, exp_valid});
    chk("m_req", {31'b0, instr_req_o}, {31'b0, exp_req});
    chk("m_we", {31'b0, instr_we_o}, 32'h0);
    chk("m_addr", instr_addr_o, mpc >> 2);
    if (exp_valid) begin
      chk("m_instr", instr_o, mq[0][63:32]);
      chk("m_pc", instr_pc_o, mq[0][31:0]);
    end
    if (rst_i) begin
      mq.delete();
      mpc = BOOT;
    end else if (branch_i) begin
      mq.delete();
      mpc = {branch_target_i[31:2], 2'b00};
    end else begin
      if (exp_pop) void'(mq.pop_front());
      if (exp_req) begin
        mq.push_back({sram_word(mpc >> 2), mpc});
        mpc = mpc + 32'd4;
      end
    end
  end

  initial begin
    rst_i = 1'b1; fetch_en_i = 1'b1; instr_ready_i = 1'b1;
    branch_i = 1'b0; branch_target_i = 32'h0;

    // reset state
    cyc(); cyc(); #1;
    chk("rst_valid", {31'b0, instr_valid_o}, 32'h0);
    chk("rst_req", {31'b0, instr_req_o}, 32'h0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_pc", instr_pc_o, 32'h0);

    // 1: streaming after reset release
    cyc(); rst_i = 1'b0; #1;
    chk("t1_addr1", instr_addr_o, 32'd1);
    chk("t1_req", {31'b0, instr_req_o}, 32'h1);
    cyc(); #1;
    chk("t1_instr_a", instr_o, 32'h1000_0001);
    chk("t1_pc_a", instr_pc_o, 32'h4);
    chk("t1_addr2", instr_addr_o, 32'd2);
    cyc(); #1;
    chk("t1_instr_b", instr_o, 32'h1000_0002);
    chk("t1_pc_b", instr_pc_o, 32'h8);

    // 2: backpressure then overlapped streaming
    cyc(); rst_i = 1'b1; instr_ready_i = 1'b0;
    cyc(); rst_i = 1'b0; #1;
    chk("t2_addr1", instr_addr_o, 32'd1);
    cyc(); cyc(); #1;
    chk("t2_req_full", {31'b0, instr_req_o}, 32'h0);
    chk("t2_addr_hold", instr_addr_o, 32'd3);
    chk("t2_pc_head", instr_pc_o, 32'h4);
    cyc(); #1;
    chk("t2_addr_hold2", instr_addr_o, 32'd3);
    chk("t2_pc_stable", instr_pc_o, 32'h4);
    instr_ready_i = 1'b1; #1;
    chk("t2_req_pop", {31'b0, instr_req_o}, 32'h1);
    cyc(); #1;
    chk("t2_pc8", instr_pc_o, 32'h8);
    cyc(); #1;
    chk("t2_pc12", instr_pc_o, 32'hC);
    cyc(); #1;
    chk("t2_pc16", instr_pc_o, 32'h10);

    // 3: redirect with full FIFO
    instr_ready_i = 1'b0;
    cyc(); cyc();
    branch_i = 1'b1; branch_target_i = 32'h58; #1;
    chk("t3_req_br", {31'b0, instr_req_o}, 32'h0);
    cyc(); branch_i = 1'b0; #1;
    chk("t3_valid0", {31'b0, instr_valid_o}, 32'h0);
    chk("t3_addr22", instr_addr_o, 32'd22);
    cyc(); #1;
    chk("t3_valid1", {31'b0, instr_valid_o}, 32'h1);
    chk("t3_pc58", instr_pc_o, 32'h58);
    chk("t3_instr22", instr_o, 32'h1000_0016);

    // 4: unaligned target
    branch_i = 1'b1; branch_target_i = 32'h5B;
    cyc(); branch_i = 1'b0; #1;
    chk("t4_addr22", instr_addr_o, 32'd22);

    // 5: reset and branch in the same cycle
    instr_ready_i = 1'b1;
    cyc(); cyc();
    rst_i = 1'b1; branch_i = 1'b1; branch_target_i = 32'h100; #1;
    chk("t5_valid", {31'b0, instr_valid_o}, 32'h0);
    chk("t5_req", {31'b0, instr_req_o}, 32'h0);
    cyc(); rst_i = 1'b0; branch_i = 1'b0; #1;
    chk("t5_addr_boot", instr_addr_o, 32'd1);

    // 6: drain with fetch disabled, then PC wrap
    instr_ready_i = 1'b0;
    cyc(); cyc();
    fetch_en_i = 1'b0; #1;
    chk("t6_req_off", {31'b0, instr_req_o}, 32'h0);
    instr_ready_i = 1'b1; #1;
    chk("t6_pc4", instr_pc_o, 32'h4);
    cyc(); #1;
    chk("t6_pc8", instr_pc_o, 32'h8);
    chk("t6_req_off2", {31'b0, instr_req_o}, 32'h0);
    cyc(); #1;
    chk("t6_empty", {31'b0, instr_valid_o}, 32'h0);
    chk("t6_hold_last", instr_pc_o, 32'h8);
    branch_i = 1'b1; branch_target_i = 32'hFFFF_FFFC;
    cyc(); branch_i = 1'b0; #1;
    chk("t6_addr_top", instr_addr_o, 32'h3FFF_FFFF);
    chk("t6_req_dis", {31'b0, instr_req_o}, 32'h0);
    fetch_en_i = 1'b1; #1;
    chk("t6_req_en", {31'b0, instr_req_o}, 32'h1);
    cyc(); #1;
    chk("t6_addr_wrap", instr_addr_o, 32'h0);
    chk("t6_pc_top", instr_pc_o, 32'hFFFF_FFFC);
    chk("t6_instr_top", instr_o, 32'h4FFF_FFFF);

    // irregular ready pattern, checked by the model only
    for (int i = 0; i < 24; i++) begin
      instr_ready_i = (i % 3) != 1;
      fetch_en_i    = (i % 7) != 5;
      branch_i      = (i == 13);
      branch_target_i = 32'h0000_0203;
      cyc();
    end
    branch_i = 1'b0;
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
